// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and byte constants for the PS/2 keyboard receiver.
// Frame FSM states and scan-code prefix / controller-response bytes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Bytes the keyboard sends as status, never as key codes.
  function automatic logic is_resp(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_BAT) ||
           (b == PS2_ECHO) || (b == PS2_ACK) ||
           (b == PS2_RESEND) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: sync + glitch filter + 11-bit frame FSM with timeout.
// Ports: vga_clk, reset (sync, high), ps2_clk/ps2_data (raw) ->
// rx_byte (last good byte), rx_byte_valid / rx_err (1-cycle strobes).
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FMAX  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TSAT  = '1;

  logic [1:0]    clk_s_q, clk_s_d;
  logic [1:0]    dat_s_q, dat_s_d;
  logic          clk_f_q, clk_f_d;
  logic          dat_f_q, dat_f_d;
  logic [FW-1:0] clk_fc_q, clk_fc_d;
  logic [FW-1:0] dat_fc_q, dat_fc_d;
  logic          clk_fp_q, clk_fp_d;
  ps2_state_e    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          fall;

  assign fall = clk_fp_q & ~clk_f_q;

  always_comb begin
    clk_s_d  = {clk_s_q[0], ps2_clk};
    dat_s_d  = {dat_s_q[0], ps2_data};
    clk_f_d  = clk_f_q;
    dat_f_d  = dat_f_q;
    clk_fc_d = '0;
    dat_fc_d = '0;
    clk_fp_d = clk_f_q;
    // A filtered line flips only on the FILTER_LEN-th differing sample.
    if (clk_s_q[1] != clk_f_q) begin
      if (clk_fc_q == FMAX) clk_f_d = clk_s_q[1];
      else                  clk_fc_d = clk_fc_q + 1'b1;
    end
    if (dat_s_q[1] != dat_f_q) begin
      if (dat_fc_q == FMAX) dat_f_d = dat_s_q[1];
      else                  dat_fc_d = dat_fc_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (state_q == IDLE || fall) tmo_d = '0;
    else if (tmo_q == TSAT)      tmo_d = tmo_q;
    else                         tmo_d = tmo_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_f_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_d  = {dat_f_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_f_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat_f_q && (^{shreg_q, par_q})) begin
            rx_byte_d  = shreg_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A real falling edge takes priority over an expiring timeout.
    if (state_q != IDLE && !fall && tmo_q == TLAST) begin
      state_d  = IDLE;
      rx_err_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      clk_s_q    <= '1;
      dat_s_q    <= '1;
      clk_f_q    <= 1'b1;
      dat_f_q    <= 1'b1;
      clk_fc_q   <= '0;
      dat_fc_q   <= '0;
      clk_fp_q   <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      clk_s_q    <= clk_s_d;
      dat_s_q    <= dat_s_d;
      clk_f_q    <= clk_f_d;
      dat_f_q    <= dat_f_d;
      clk_fc_q   <= clk_fc_d;
      dat_fc_q   <= dat_fc_d;
      clk_fp_q   <= clk_fp_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_valid_q;
  assign rx_err        = rx_err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with E0/F0 prefix decoding.
// Ports: vga_clk, reset, ps2_clk, ps2_data in; rx_byte/rx_byte_valid/
// rx_err and key_code/key_ext/key_release/key_valid out.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid
);

  logic       ext_pend_q, ext_pend_d;
  logic       rel_pend_q, rel_pend_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_rel_q, key_rel_d;
  logic       key_valid_q, key_valid_d;
  logic       is_ext, is_brk, is_clr, is_key;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_err        (rx_err)
  );

  // Mutually exclusive: the frame rx never raises valid and err together.
  assign is_ext = rx_byte_valid && (rx_byte == PS2_EXT);
  assign is_brk = rx_byte_valid && (rx_byte == PS2_BRK);
  assign is_clr = rx_err || (rx_byte_valid &&
                  ((rx_byte == PS2_PAUSE) || is_resp(rx_byte)));
  assign is_key = rx_byte_valid && !is_ext && !is_brk && !is_clr;

  always_comb begin
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    key_valid_d = 1'b0;
    unique case (1'b1)
      is_ext: ext_pend_d = 1'b1;
      is_brk: rel_pend_d = 1'b1;
      is_clr: begin
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end
      is_key: begin
        key_code_d  = rx_byte;
        key_ext_d   = ext_pend_q;
        key_rel_d   = rel_pend_q;
        key_valid_d = 1'b1;
        ext_pend_d  = 1'b0;
        rel_pend_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_rel_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed + random PS/2 frames against a byte-level
// event model; strobes are counted per cycle and compared after each frame.
module tb_ps2_kbd_rx;

  localparam int HB   = 25;
  localparam int TOUT = 50000;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;

  ps2_kbd_rx dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_err        (rx_err),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_release   (key_release),
    .key_valid     (key_valid)
  );

  always #20 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int n_rxv = 0, n_err = 0, n_key = 0;
  int last_rxv_cyc = 0, last_err_cyc = 0;
  always @(negedge vga_clk) begin
    if (rx_byte_valid) begin
      n_rxv = n_rxv + 1;
      last_rxv_cyc = cyc;
    end
    if (rx_err) begin
      n_err = n_err + 1;
      last_err_cyc = cyc;
    end
    if (key_valid) n_key = n_key + 1;
  end

  int total = 0, bad = 0;
  int fall_cyc = 0;

  // Reference model: expected outputs as a function of received bytes.
  logic [7:0] m_byte = 8'h00, m_code = 8'h00;
  logic m_ext = 1'b0, m_rel = 1'b0, m_kext = 1'b0, m_krel = 1'b0;
  int e_rxv = 0, e_err = 0, e_key = 0;
  logic [7:0] no_key[$] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic ok);
    logic silent;
    if (!ok) begin
      e_err = e_err + 1;
      m_ext = 1'b0;
      m_rel = 1'b0;
      return;
    end
    e_rxv = e_rxv + 1;
    m_byte = b;
    silent = 1'b0;
    foreach (no_key[i]) if (no_key[i] == b) silent = 1'b1;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (silent) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      e_key = e_key + 1;
      m_code = b;
      m_kext = m_ext;
      m_krel = m_rel;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_byte = 8'h00;
    m_code = 8'h00;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_kext = 1'b0;
    m_krel = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic par_bad,
                      input logic stop_bad, input int nbits);
    logic [10:0] f;
    f[0] = 1'b0;
    f[8:1] = b;
    f[9] = (~^b) ^ par_bad;
    f[10] = ~stop_bad;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HB);
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HB);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HB + 20);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rxv_cnt"}, n_rxv, e_rxv);
    chk({tag, ".err_cnt"}, n_err, e_err);
    chk({tag, ".key_cnt"}, n_key, e_key);
    chk({tag, ".rx_byte"}, {24'h0, rx_byte}, {24'h0, m_byte});
    chk({tag, ".key_code"}, {24'h0, key_code}, {24'h0, m_code});
    chk({tag, ".key_ext"}, {31'h0, key_ext}, {31'h0, m_kext});
    chk({tag, ".key_rel"}, {31'h0, key_release}, {31'h0, m_krel});
  endtask

  task automatic frame(input string tag, input logic [7:0] b,
                       input logic par_bad, input logic stop_bad);
    send(b, par_bad, stop_bad, 11);
    model_frame(b, !(par_bad || stop_bad));
    check_all(tag);
  endtask

  initial begin
    int d;
    logic [7:0] b;
    int k;
    wait_cyc(5);
    check_all("reset");
    reset = 1'b0;
    wait_cyc(20);

    frame("make_1c", 8'h1C, 1'b0, 1'b0);
    d = last_rxv_cyc - fall_cyc;
    chk("latency", {31'h0, (d >= 10 && d <= 12)}, 32'h1);

    frame("ext_e0", 8'hE0, 1'b0, 1'b0);
    frame("brk_f0", 8'hF0, 1'b0, 1'b0);
    frame("key_75", 8'h75, 1'b0, 1'b0);

    frame("e0_pre", 8'hE0, 1'b0, 1'b0);
    frame("par_bad", 8'h75, 1'b1, 1'b0);
    frame("after_par", 8'h6B, 1'b0, 1'b0);

    frame("f0_pre", 8'hF0, 1'b0, 1'b0);
    frame("stop_bad", 8'h1C, 1'b0, 1'b1);
    frame("after_stop", 8'h6B, 1'b0, 1'b0);

    frame("e0_tmo", 8'hE0, 1'b0, 1'b0);
    send(8'h6B, 1'b0, 1'b0, 5);
    wait_cyc(TOUT + 100);
    model_frame(8'h00, 1'b0);
    check_all("timeout");
    d = last_err_cyc - fall_cyc;
    chk("tmo_delay", {31'h0, (d >= TOUT && d <= TOUT + 40)}, 32'h1);
    frame("after_tmo", 8'h6B, 1'b0, 1'b0);

    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    check_all("glitch");
    frame("bat_aa", 8'hAA, 1'b0, 1'b0);

    frame("e0_rst", 8'hE0, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b0, 4);
    reset = 1'b1;
    wait_cyc(3);
    model_reset();
    check_all("mid_reset");
    reset = 1'b0;
    wait_cyc(20);
    frame("after_rst", 8'h5A, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2) b = 8'hE0;
      else if (k == 2) b = 8'hF0;
      else if (k == 3) b = no_key[$urandom_range(0, 6)];
      else b = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 9);
      frame($sformatf("rnd%0d", i), b, k == 0, k == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Upstream stage of the video/keyboard demo: turns raw PS/2 keyboard lines into validated scan-code bytes and decoded key events.
- Runs in the 25 MHz vga_clk domain.
- Replaces ad-hoc edge counting with start/parity/stop checking, glitch filtering and timeout resync.
- Downstream game logic consumes key_valid/key_code/key_ext/key_release only.

Parameters:
- FILTER_LEN, 8, consecutive identical synced samples needed before a filtered PS/2 line changes.
- TIMEOUT_CYCLES, 50000, vga_clk cycles (2 ms) without a filtered falling edge mid-frame before the frame is aborted.

Ports:
- vga_clk  in  1  system clock, 25 MHz
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- rx_byte  out  8  last correctly received byte
- rx_byte_valid  out  1  one-cycle strobe, rx_byte updated
- rx_err  out  1  one-cycle strobe on parity, stop or timeout error
- key_code  out  8  scan code of the last key event
- key_ext  out  1  event was E0-prefixed
- key_release  out  1  event was F0-prefixed (break)
- key_valid  out  1  one-cycle strobe, key_* updated

Behaviour:
- Clock and reset: one clock (vga_clk); reset is synchronous and active-high.
- Reset values: all outputs 0; sync and filter registers 1; FSM IDLE; pending flags 0; timeout counter 0.
- Synchronisation: 2-FF synchroniser on each line.
- Filtering: filtered line copies the synced value only after FILTER_LEN consecutive equal samples. fall = filtered ps2_clk 1->0, one-cycle strobe.
- Frame format: start 0, d0..d7 LSB first, odd parity, stop 1. Data is sampled (filtered ps2_data) on fall.
- FSM:
  - IDLE: on fall with data=0 -> DATA, bitcnt=0. On fall with data=1 -> stay; no error.
  - DATA: on fall, shreg <= {data, shreg[7:1]} and bitcnt++. After the 8th bit -> PARITY.
  - PARITY: on fall, latch parity bit -> STOP.
  - STOP: on fall, check stop==1 and XOR of shreg and parity == 1.
    - Pass: next cycle rx_byte<=shreg and rx_byte_valid=1.
    - Fail: next cycle rx_err=1; rx_byte holds its old value.
    - Either way -> IDLE.
- Timeout:
  - Counter clears on every fall and in IDLE; it saturates.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 gives -> IDLE plus a one-cycle rx_err.
  - fall and timeout in the same cycle: fall wins.
- Latency: rx_byte_valid rises 2 + FILTER_LEN + 1 cycles after the raw stop-bit falling edge, ±1 cycle.
- Decoder, acting on rx_byte_valid, updates in the following cycle:
  - 0xE0: ext_pend<=1, no event.
  - 0xF0: rel_pend<=1, no event.
  - 0xE1: clear both pending flags, no event. The remaining Pause bytes decode as ordinary codes; this is accepted.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF (controller responses): clear pending flags, no key event.
  - Any other byte: key_code<=byte, key_ext<=ext_pend, key_release<=rel_pend, key_valid=1, then clear pending flags.
- rx_err also clears ext_pend and rel_pend.
- key_* and rx_byte hold their values between strobes. Strobes are never asserted for more than one cycle.
- Reset mid-frame: FSM returns to IDLE immediately. A trailing partial frame is rejected by parity/stop check or timeout. No valid strobe may result from a truncated frame.
- Widths: bitcnt 4 bits. Timeout counter is $clog2(TIMEOUT_CYCLES) bits. Filter counter is $clog2(FILTER_LEN) bits, saturating.

Decomposition:
- Package ps2_pkg:
  - FSM state enum {IDLE, DATA, PARITY, STOP}
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ECHO=8'hEE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM and timeout; outputs rx_byte/rx_byte_valid/rx_err.
- ps2_kbd_rx top: instantiates ps2_frame_rx and holds the prefix decoder.

Test Plan:
- Frame 0x1C, parity 0, 80 µs bit period -> one rx_byte_valid with rx_byte=0x1C; next cycle key_valid, key_code=0x1C, key_ext=0, key_release=0.
- Frames E0, F0, 75 -> three rx_byte_valid pulses; exactly one key_valid with key_code=0x75, key_ext=1, key_release=1.
- Frame E0, then 0x75 with parity bit 1 -> rx_err pulse, no rx_byte_valid; following good 0x6B -> key_ext=0.
- Frame 0x6B with stop bit 0 -> rx_err pulse, rx_byte unchanged, no key_valid.
- Send 5 bits, then hold lines high for 60000 cycles -> exactly one rx_err, about 50000 cycles after the last fall; subsequent good 0x6B decodes correctly.
- 3-cycle low glitch on ps2_clk during idle -> no state change. Frame 0xAA -> rx_byte_valid, rx_byte=0xAA, no key_valid.
